div_result_fixup: RTL

- Downstream stage of the combinational unsigned divider core.
- Consumes the divider's unsigned quotient/remainder magnitudes plus the original operands. Applies signed-result correction, divide-by-zero and overflow special cases.
- Buffers results in a 2-entry output FIFO with valid/ready handshakes on both sides, decoupling the divider from the writeback consumer.

---
 rtl/div_result_fixup.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/div_result_fixup.sv
// ============================================================================
// Module   : div_result_fixup
// Purpose  : Signed/zero/overflow correction of divider results, buffered in a
//            2-entry valid/ready FIFO. Optional status bits via DIV_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_fixup #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] q_u,
  input  logic [WIDTH-1:0] r_u,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_STATUS_EN
  ,
  output logic             out_dz,
  output logic             out_ovf
`endif
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic             fix_dz;
  logic             fix_ovf;
  logic             sx;
  logic             sy;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  always_comb begin
    fix_dz  = (y == '0);
    fix_ovf = signed_op && (x == MIN_NEG) && (y == ALL_ONES);
    sx      = signed_op & x[WIDTH-1];
    sy      = signed_op & y[WIDTH-1];
    fix_q   = q_u;
    fix_r   = r_u;
    if (fix_dz) begin
      fix_q = ALL_ONES;
      fix_r = x;
    end else if (fix_ovf) begin
      fix_q = x;
      fix_r = '0;
    end else begin
      fix_q = (sx ^ sy) ? ('0 - q_u) : q_u;
      fix_r = sx ? ('0 - r_u) : r_u;
    end
  end

  logic [1:0]       count;
  logic [1:0]       count_n;
  logic             wptr;
  logic             rptr;
  logic             rptr_n;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] q_mem [2];
  logic [WIDTH-1:0] r_mem [2];
  logic             head_from_push;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rptr_n    = rptr ^ pop;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
    // The head after this edge is either the entry being written now or a stored one.
    head_from_push = push && (wptr == rptr_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      count <= count_n;
      rptr  <= rptr_n;
      if (push) wptr <= ~wptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wptr] <= fix_q;
      r_mem[wptr] <= fix_r;
    end
  end

  // Output registers hold the last head when the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      r <= '0;
    end else if (count_n != 2'd0) begin
      q <= head_from_push ? fix_q : q_mem[rptr_n];
      r <= head_from_push ? fix_r : r_mem[rptr_n];
    end
  end

`ifdef DIV_STATUS_EN
  logic dz_mem  [2];
  logic ovf_mem [2];

  always_ff @(posedge clk) begin
    if (push) begin
      dz_mem[wptr]  <= fix_dz;
      ovf_mem[wptr] <= fix_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dz  <= 1'b0;
      out_ovf <= 1'b0;
    end else if (count_n != 2'd0) begin
      out_dz  <= head_from_push ? fix_dz  : dz_mem[rptr_n];
      out_ovf <= head_from_push ? fix_ovf : ovf_mem[rptr_n];
    end
  end
`endif

endmodule

`default_nettype wire
